// File: rtl/fft_processor.sv
// rtl/fft_processor.sv - in-place radix-2 DIT FFT engine, mic-side sample load, VGA-side bin read
// Optional busy output port enabled by defining FFT_BUSY_OUT_EN.
module fft_processor #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mic_we,
    input  logic [ADDR_WIDTH-1:0]        mic_addr,
    input  logic signed [DATA_WIDTH-1:0] mic_data,
    input  logic [ADDR_WIDTH-1:0]        vga_addr,
    output logic signed [DATA_WIDTH-1:0] vga_data_r,
    output logic signed [DATA_WIDTH-1:0] vga_data_i,
    output logic                         done
`ifdef FFT_BUSY_OUT_EN
    ,
    output logic                         busy
`endif
);
    localparam int  N  = 1 << ADDR_WIDTH;
    localparam int  HN = N / 2;
    localparam int  BW = ADDR_WIDTH - 1;
    localparam int  SW = $clog2(ADDR_WIDTH + 1);
    localparam int  TW = 18;
    localparam int  PW = DATA_WIDTH + TW + 1;
    localparam int  EW = DATA_WIDTH + 2;
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                       state_q, state_d;
    logic [SW-1:0]                stage_q, stage_d;
    logic [BW-1:0]                bfly_q, bfly_d;
    logic signed [DATA_WIDTH-1:0] re_q [N];
    logic signed [DATA_WIDTH-1:0] im_q [N];

    // Twiddle ROM: W^m = cos - j*sin in Q2.16, rounded to nearest at elaboration
    logic signed [TW-1:0] tw_re [HN];
    logic signed [TW-1:0] tw_im [HN];
    for (genvar m = 0; m < HN; m++) begin : g_tw
        localparam real CR = 65536.0 * $cos(2.0 * PI * m / N);
        localparam real SR = 65536.0 * $sin(2.0 * PI * m / N);
        localparam int  CI = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        localparam int  SI = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
        assign tw_re[m] = TW'(CI);
        assign tw_im[m] = TW'(-SI);
    end

    // stage_q == ADDR_WIDTH is the one settle cycle between the last write and DONE
    logic running;
    assign running = (state_q == BUSY) && (stage_q != SW'(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] b_ext, h, low_mask, top_idx, bot_idx, mic_rev;
    logic [BW-1:0]         tw_idx;
    always_comb begin
        b_ext    = {1'b0, bfly_q};
        h        = ADDR_WIDTH'(1) << stage_q;
        low_mask = h - ADDR_WIDTH'(1);
        top_idx  = ((b_ext >> stage_q) << (stage_q + SW'(1))) | (b_ext & low_mask);
        bot_idx  = top_idx | h;
        tw_idx   = BW'((b_ext & low_mask) << (SW'(BW) - stage_q));
        mic_rev  = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) mic_rev[i] = mic_addr[ADDR_WIDTH-1-i];
    end

    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0]         w_re, w_im;
    logic signed [PW-1:0]         p_re, p_im;
    logic signed [EW-1:0]         t_re, t_im, sum_re, sum_im, dif_re, dif_im;
    always_comb begin
        a_re   = re_q[top_idx];
        a_im   = im_q[top_idx];
        b_re   = re_q[bot_idx];
        b_im   = im_q[bot_idx];
        w_re   = tw_re[tw_idx];
        w_im   = tw_im[tw_idx];
        p_re   = (PW'(b_re) * PW'(w_re)) - (PW'(b_im) * PW'(w_im));
        p_im   = (PW'(b_re) * PW'(w_im)) + (PW'(b_im) * PW'(w_re));
        t_re   = EW'(p_re >>> 16);
        t_im   = EW'(p_im >>> 16);
        sum_re = EW'(a_re) + t_re;
        sum_im = EW'(a_im) + t_im;
        dif_re = EW'(a_re) - t_re;
        dif_im = EW'(a_im) - t_im;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (running) begin
                re_q[top_idx] <= DATA_WIDTH'(sum_re >>> 1);
                im_q[top_idx] <= DATA_WIDTH'(sum_im >>> 1);
                re_q[bot_idx] <= DATA_WIDTH'(dif_re >>> 1);
                im_q[bot_idx] <= DATA_WIDTH'(dif_im >>> 1);
            end else if (mic_we && state_q != BUSY) begin
                re_q[mic_rev] <= mic_data;
                im_q[mic_rev] <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = BUSY;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            BUSY: begin
                if (!running) begin
                    state_d = DONE;
                end else begin
                    bfly_d = bfly_q + BW'(1);
                    if (bfly_q == '1) stage_d = stage_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    assign vga_data_r = re_q[vga_addr];
    assign vga_data_i = im_q[vga_addr];
    assign done       = (state_q == DONE);
`ifdef FFT_BUSY_OUT_EN
    assign busy       = (state_q == BUSY);
`endif
endmodule

// File: tb/tb_fft_processor.sv
// tb/tb_fft_processor.sv - randomized and directed bench for fft_processor against an arithmetic FFT/DFT model
module tb_fft_processor;
    localparam int  AW  = 5;
    localparam int  DW  = 18;
    localparam int  N   = 32;
    localparam int  HN  = 16;
    localparam int  LAT = AW * HN + 1;
    localparam real PI  = 3.14159265358979323846;

    logic                 clk = 1'b0;
    logic                 rst, start, mic_we;
    logic [AW-1:0]        mic_addr, vga_addr;
    logic signed [DW-1:0] mic_data, vga_data_r, vga_data_i;
    logic                 done;
`ifdef FFT_BUSY_OUT_EN
    logic                 busy;
`endif

    int     total = 0;
    int     bad   = 0;
    longint xin [N];
    longint mre [N];
    longint mim [N];
    longint gre [N];
    longint gim [N];
    longint twr [HN];
    longint twi [HN];

    fft_processor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mic_we(mic_we),
        .mic_addr(mic_addr), .mic_data(mic_data), .vga_addr(vga_addr),
        .vga_data_r(vga_data_r), .vga_data_i(vga_data_i), .done(done)
`ifdef FFT_BUSY_OUT_EN
        , .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd(input real r);
        return (r >= 0.0) ? longint'($rtoi(r + 0.5)) : -longint'($rtoi(0.5 - r));
    endfunction

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < AW; i++) if (v[i]) r |= 1 << (AW - 1 - i);
        return r;
    endfunction

    // Scaled DIT FFT straight from the butterfly rules, on plain integers
    task automatic model_fft();
        longint ar, ai, br, bi, tr, ti;
        int h, top, bot, m;
        for (int n = 0; n < N; n++) begin
            mre[bitrev(n)] = xin[n];
            mim[bitrev(n)] = 0;
        end
        for (int s = 0; s < AW; s++) begin
            for (int b = 0; b < HN; b++) begin
                h   = 1 << s;
                top = ((b >> s) << (s + 1)) + (b % h);
                bot = top + h;
                m   = (b % h) * (HN >> s);
                ar = mre[top]; ai = mim[top]; br = mre[bot]; bi = mim[bot];
                tr = (br * twr[m] - bi * twi[m]) >>> 16;
                ti = (br * twi[m] + bi * twr[m]) >>> 16;
                mre[top] = (ar + tr) >>> 1;
                mim[top] = (ai + ti) >>> 1;
                mre[bot] = (ar - tr) >>> 1;
                mim[bot] = (ai - ti) >>> 1;
            end
        end
    endtask

    task automatic load(input int count);
        for (int n = 0; n < count; n++) begin
            mic_we = 1'b1; mic_addr = AW'(n); mic_data = DW'(xin[n]);
            @(posedge clk); #1;
        end
        mic_we = 1'b0;
    endtask

    task automatic run(input string tag, input bit restart, input bit poke);
        int cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mic_we = 1'b0;
        check({tag, "_done_drop"}, longint'(done), 0);
        while (done !== 1'b1 && cyc < 200) begin
            start    = restart && (cyc == 10);
            mic_we   = poke && (cyc == 5);
            mic_addr = AW'(3);
            mic_data = DW'(12345);
`ifdef FFT_BUSY_OUT_EN
            if (cyc == 40) check({tag, "_busy"}, longint'(busy), 1);
`endif
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; mic_we = 1'b0;
        check({tag, "_latency"}, cyc, LAT);
    endtask

    task automatic read_all();
        for (int k = 0; k < N; k++) begin
            vga_addr = AW'(k); #1;
            gre[k] = vga_data_r;
            gim[k] = vga_data_i;
        end
    endtask

    task automatic compare_model(input string tag);
        model_fft();
        read_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_re[%0d]", tag, k), gre[k], mre[k]);
            check($sformatf("%s_im[%0d]", tag, k), gim[k], mim[k]);
        end
    endtask

    task automatic compare_const(input string tag, input int hot, input longint hot_val);
        read_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_re[%0d]", tag, k), gre[k], (hot < 0 || k == hot) ? hot_val : 0);
            check($sformatf("%s_im[%0d]", tag, k), gim[k], 0);
        end
    endtask

    task automatic randomize_x(input int span);
        for (int n = 0; n < N; n++)
            xin[n] = longint'($urandom_range(0, 2 * span)) - span;
    endtask

    initial begin
        real    rr, ri;
        longint er, ei, d;
        rst = 1'b1; start = 1'b0; mic_we = 1'b0;
        mic_addr = '0; mic_data = '0; vga_addr = '0;
        for (int m = 0; m < HN; m++) begin
            twr[m] = rnd(65536.0 * $cos(2.0 * PI * m / N));
            twi[m] = -rnd(65536.0 * $sin(2.0 * PI * m / N));
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", longint'(done), 0);
`ifdef FFT_BUSY_OUT_EN
        check("rst_busy", longint'(busy), 0);
`endif
        rst = 1'b0;
        run("empty", 0, 0);

        for (int n = 0; n < N; n++) xin[n] = 100;
        load(N); run("dc", 0, 0); compare_const("dc", 0, 100);

        for (int n = 0; n < N; n++) xin[n] = (n == 0) ? 3200 : 0;
        load(N); run("imp", 0, 0); compare_const("imp", -1, 100);

        // Restart and sample writes while busy must both be ignored
        for (int n = 0; n < N; n++) xin[n] = (n % 2 == 0) ? 100 : -100;
        load(N); run("alt", 1, 1); compare_const("alt", 16, 100);

        randomize_x(500);
        xin[0] = 424; xin[1] = 326; xin[2] = -426; xin[N-1] = -193;
        load(N); run("mix", 0, 0); compare_model("mix");
        for (int k = 0; k < N; k++) begin
            rr = 0.0; ri = 0.0;
            for (int n = 0; n < N; n++) begin
                rr += real'(xin[n]) * $cos(2.0 * PI * k * n / N);
                ri -= real'(xin[n]) * $sin(2.0 * PI * k * n / N);
            end
            er = rnd(rr / N); ei = rnd(ri / N);
            d = gre[k] - er;
            check($sformatf("dft_re[%0d]", k), (d > 3 || d < -3) ? gre[k] : er, er);
            d = gim[k] - ei;
            check($sformatf("dft_im[%0d]", k), (d > 3 || d < -3) ? gim[k] : ei, ei);
        end
        for (int k = 1; k < N; k++) begin
            d = gre[k] - gre[N-k];
            check($sformatf("sym_re[%0d]", k), (d > 2 || d < -2) ? gre[k] : gre[N-k], gre[N-k]);
            d = gim[k] + gim[N-k];
            check($sformatf("sym_im[%0d]", k), (d > 2 || d < -2) ? gim[k] : -gim[N-k], -gim[N-k]);
        end

        load(N);
        check("load_keeps_done", longint'(done), 1);
        run("rerun", 0, 0); compare_model("rerun");

        for (int v = 0; v < 2; v++) begin
            randomize_x(60000);
            load(N); run($sformatf("rnd%0d", v), 0, 0); compare_model($sformatf("rnd%0d", v));
        end

        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check("abort_done", longint'(done), 0);
        repeat (100) @(posedge clk);
        #1;
        check("abort_idle", longint'(done), 0);
`ifdef FFT_BUSY_OUT_EN
        check("abort_busy", longint'(busy), 0);
`endif

        // Last sample written on the same edge as start must be part of the transform
        randomize_x(60000);
        load(N - 1);
        mic_we = 1'b1; mic_addr = AW'(N - 1); mic_data = DW'(xin[N-1]);
        run("wr_start", 0, 0); compare_model("wr_start");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_processor.md
Name: fft_processor

Overview:
- In-place radix-2 decimation-in-time FFT engine for the audio visualizer, 2**ADDR_WIDTH points.
- Sits between the microphone sample writer and the VGA spectrum reader.
- Mic side writes real samples by address. A start pulse runs the transform. The VGA side reads complex bins by address once done is high.

Parameters:
- ADDR_WIDTH, 5, log2 of FFT length N (N = 32 default); supported range 2..10.
- DATA_WIDTH, 18, signed two's-complement width of samples and of each output component.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a transform.
- mic_we  input  1  sample write enable.
- mic_addr  input  ADDR_WIDTH  time index n of the sample being written.
- mic_data  input  DATA_WIDTH  signed sample x[n] (real part; imaginary part is implicitly 0).
- vga_addr  input  ADDR_WIDTH  frequency bin k to read.
- vga_data_r  output  DATA_WIDTH  signed real part of X[k].
- vga_data_i  output  DATA_WIDTH  signed imaginary part of X[k].
- done  output  1  high while a valid result set is held.

Behaviour:
- Storage: N-entry complex register array (re, im, DATA_WIDTH each), used in place for input, intermediate and output data.
- Load: on a clk edge with mic_we=1 and FSM in IDLE or DONE, write re=mic_data and im=0 at bitreverse(mic_addr, ADDR_WIDTH).
  - This overwrites any held result at that slot; done is not changed.
  - mic_we while BUSY is ignored.
- Read: vga_data_r/vga_data_i are combinational from array[vga_addr].
  - After done, array[k] holds bin k in natural order.
  - During BUSY, the outputs show intermediate values and are not meaningful.
- FSM states: IDLE, BUSY, DONE.
  - Reset puts the FSM in IDLE and clears stage/butterfly counters and done to 0. Array contents are not reset.
  - IDLE or DONE, start=1: go to BUSY; done drops to 0 the same edge.
  - BUSY: start is ignored.
  - BUSY to DONE: after the last butterfly of the last stage has been written.
  - DONE: done=1; held until the next start or rst.
- Schedule: one butterfly per clock.
  - Stages s = 0..ADDR_WIDTH-1; butterflies b = 0..N/2-1 per stage.
  - Span h = 2**s. Pair indices: top = ((b >> s) << (s+1)) + (b mod h), bottom = top + h.
  - Twiddle index = (b mod h) * (N/2 >> s).
- Latency: done is high on the edge ADDR_WIDTH*N/2 + 1 cycles after the edge that samples start (81 cycles for N=32).
- Twiddle ROM:
  - N/2 entries of W^m = cos(2πm/N) - j·sin(2πm/N), each component 18-bit signed Q2.16, rounded to nearest.
  - W^0 = (65536, 0) exactly.
  - Generated at elaboration for any supported ADDR_WIDTH.
- Butterfly arithmetic:
  - t = B·W, using full-precision complex multiply with each product component arithmetic-shifted right by 16 (floor).
  - A' = (A + t) >>> 1 and B' = (A - t) >>> 1, computed in DATA_WIDTH+2 bits and then truncated to DATA_WIDTH.
  - Final result is therefore DFT/N (1/2 scaling per stage); overflow is impossible for inputs within range.
- Simultaneous events:
  - rst has priority over everything.
  - start and mic_we on the same edge in IDLE/DONE: the write completes and the transform then starts on the updated array.
  - Reset mid-BUSY aborts to IDLE with done=0; the array is left partially transformed.

Optional Feature:
- Macro FFT_BUSY_OUT_EN.
- When defined: adds output port busy (1 bit), high exactly while the FSM is in BUSY, 0 after reset.
- When undefined: no busy port; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> done=0; a start with no loaded data still completes and sets done after 81 cycles.
- DC: write x[n]=100 for all 32 n, pulse start -> done after 81 cycles; bin0 = (100, 0), bins 1..31 = (0, 0).
- Impulse: x[0]=3200, all others 0 -> every bin k = (100, 0).
- Alternating: x[n]=+100 for even n, -100 for odd n -> bin16 = (100, 0), all other bins (0, 0).
- Handshake:
  - start pulsed again at cycle 10 of BUSY -> ignored; done still at 81.
  - mic_we during BUSY -> array unaffected.
  - A second start from DONE -> done drops next edge and a full rerun produces identical results.
- Mixed 32-sample vector (424, 326, -426, ... -193) -> each bin within ±3 LSB of the double-precision DFT/32.
  - Conjugate symmetry re[k]=re[32-k], im[k]=-im[32-k] within ±2 LSB.
